// File: rtl/parking_access_fsm.sv
// Parking access gate controller: Moore FSM with wrong-PIN counter and try-strobe edge detect.
// Optional AUTH timeout is compiled in when GATE_TIMEOUT_EN is defined.
module parking_access_fsm #(
   parameter logic [7:0] PASSWORD       = 8'h57,
   parameter int         MAX_ATTEMPTS   = 3,
   parameter int         TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sensor_1,
   input  logic       sensor_2,
   input  logic [7:0] psswrd_atmpt,
   input  logic       try_psswrd,
   output logic       alarm_1,
   output logic       alarm_2,
   output logic       open_gate,
   output logic       close_gate
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PIN   = 3'd1,
      AUTH  = 3'd2,
      BLOCK = 3'd3,
      LOCK  = 3'd4
   } state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_ATTEMPTS);

   if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 15 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("parking_access_fsm: parameter out of legal range");
   end

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] cnt_inc_s;
   logic       try_q;
   logic       attempt_s;
   logic       pin_ok_s;
   logic       both_s;
   logic       tmo_s;
   logic       alarm_1_q, alarm_1_d;
   logic       alarm_2_q, alarm_2_d;
   logic       open_q, open_d;
   logic       close_q, close_d;

   assign attempt_s = try_psswrd & ~try_q;
   assign pin_ok_s  = (psswrd_atmpt == PASSWORD);
   assign both_s    = sensor_1 & sensor_2;
   assign cnt_inc_s = (cnt_q < MAX_CNT) ? (cnt_q + 4'd1) : cnt_q;

`ifdef GATE_TIMEOUT_EN
   localparam int            TW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmo_q, tmo_d;

   assign tmo_s = (tmo_q == TMO_LAST);

   // Timeout counter restarts on AUTH entry and counts while AUTH persists.
   always_comb begin
      tmo_d = '0;
      if (state_q == AUTH && state_d == AUTH) begin
         tmo_d = tmo_q + TW'(1);
      end else begin
         tmo_d = '0;
      end
   end

   // Timeout counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign tmo_s = 1'b0;
`endif

   // Next-state and attempt-counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (both_s)        state_d = BLOCK;
            else if (sensor_1) state_d = PIN;
            else               state_d = IDLE;
         end
         PIN: begin
            if (both_s) begin
               state_d = BLOCK;
            end else if (attempt_s && pin_ok_s) begin
               state_d = AUTH;
               cnt_d   = 4'd0;
            end else if (attempt_s) begin
               cnt_d   = cnt_inc_s;
               state_d = (cnt_inc_s == MAX_CNT) ? LOCK : PIN;
            end else if (!sensor_1) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               state_d = PIN;
            end
         end
         AUTH: begin
            if (both_s)        state_d = BLOCK;
            else if (sensor_2) state_d = IDLE;
            else if (tmo_s)    state_d = IDLE;
            else               state_d = AUTH;
         end
         BLOCK: begin
            if (attempt_s && pin_ok_s) state_d = IDLE;
            else                       state_d = BLOCK;
         end
         LOCK:    state_d = LOCK;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from next state so they register alongside the state.
   always_comb begin
      alarm_1_d = 1'b0;
      alarm_2_d = 1'b0;
      open_d    = 1'b0;
      close_d   = 1'b1;
      case (state_d)
         AUTH: begin
            open_d  = 1'b1;
            close_d = 1'b0;
         end
         BLOCK:   alarm_2_d = 1'b1;
         LOCK:    alarm_1_d = 1'b1;
         default: close_d   = 1'b1;
      endcase
   end

   // State, counter, try history and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         try_q     <= 1'b0;
         alarm_1_q <= 1'b0;
         alarm_2_q <= 1'b0;
         open_q    <= 1'b0;
         close_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         try_q     <= try_psswrd;
         alarm_1_q <= alarm_1_d;
         alarm_2_q <= alarm_2_d;
         open_q    <= open_d;
         close_q   <= close_d;
      end
   end

   assign alarm_1    = alarm_1_q;
   assign alarm_2    = alarm_2_q;
   assign open_gate  = open_q;
   assign close_gate = close_q;
endmodule

// File: tb/tb_parking_access_fsm.sv
// Scoreboard bench for parking_access_fsm: directed steps push expected outputs,
// a monitor pops and compares one cycle later. Output vector is {alarm_1, alarm_2, open_gate, close_gate}.
module tb_parking_access_fsm;
   logic       clk = 1'b0;
   logic       rst;
   logic       sensor_1;
   logic       sensor_2;
   logic [7:0] psswrd_atmpt;
   logic       try_psswrd;
   logic       alarm_1;
   logic       alarm_2;
   logic       open_gate;
   logic       close_gate;

   localparam logic [3:0] O_IDLE  = 4'b0001;
   localparam logic [3:0] O_AUTH  = 4'b0010;
   localparam logic [3:0] O_BLOCK = 4'b0101;
   localparam logic [3:0] O_LOCK  = 4'b1001;

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] exp_q[$];
   string      name_q[$];

   parking_access_fsm dut (
      .clk          (clk),
      .rst          (rst),
      .sensor_1     (sensor_1),
      .sensor_2     (sensor_2),
      .psswrd_atmpt (psswrd_atmpt),
      .try_psswrd   (try_psswrd),
      .alarm_1      (alarm_1),
      .alarm_2      (alarm_2),
      .open_gate    (open_gate),
      .close_gate   (close_gate)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got a1/a2/open/close=%b expected %b", name, act, exp);
      end
   endtask

   task automatic step(input logic s1, input logic s2, input logic [7:0] pin,
                       input logic tr, input logic [3:0] exp, input string name);
      @(negedge clk);
      sensor_1     = s1;
      sensor_2     = s2;
      psswrd_atmpt = pin;
      try_psswrd   = tr;
      exp_q.push_back(exp);
      name_q.push_back(name);
   endtask

   task automatic async_reset(input string name);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check(name, {alarm_1, alarm_2, open_gate, close_gate}, O_IDLE);
      sensor_1     = 1'b0;
      sensor_2     = 1'b0;
      psswrd_atmpt = 8'h00;
      try_psswrd   = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Monitor: compare the response to each issued step just after the clock edge.
   initial begin
      logic [3:0] e;
      string      n;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, {alarm_1, alarm_2, open_gate, close_gate}, e);
         end
      end
   end

   initial begin
      rst          = 1'b1;
      sensor_1     = 1'b0;
      sensor_2     = 1'b0;
      psswrd_atmpt = 8'h00;
      try_psswrd   = 1'b0;
      #2 rst = 1'b0;
      #1 check("reset_values", {alarm_1, alarm_2, open_gate, close_gate}, O_IDLE);
      @(negedge clk);
      rst = 1'b1;

      // Normal entry
      step(1'b0, 1'b0, 8'h00, 1'b0, O_IDLE, "idle_hold");
      step(1'b1, 1'b0, 8'h00, 1'b0, O_IDLE, "to_pin");
      step(1'b1, 1'b0, 8'h57, 1'b1, O_AUTH, "good_pin_auth");
      step(1'b0, 1'b0, 8'h57, 1'b0, O_AUTH, "auth_s1_drop");
      step(1'b0, 1'b1, 8'h00, 1'b0, O_IDLE, "auth_s2_idle");

      // Two wrong, then correct on the same edge sensor_1 falls
      step(1'b1, 1'b0, 8'h00, 1'b0, O_IDLE, "pin2_enter");
      step(1'b1, 1'b0, 8'h5F, 1'b1, O_IDLE, "wrong_1");
      step(1'b1, 1'b0, 8'h5F, 1'b0, O_IDLE, "wrong_1_rel");
      step(1'b1, 1'b0, 8'h5F, 1'b1, O_IDLE, "wrong_2");
      step(1'b1, 1'b0, 8'h5F, 1'b0, O_IDLE, "wrong_2_rel");
      step(1'b0, 1'b0, 8'h57, 1'b1, O_AUTH, "good_with_s1_fall");
      step(1'b0, 1'b1, 8'h00, 1'b0, O_IDLE, "auth2_exit");
      step(1'b0, 1'b0, 8'h00, 1'b0, O_IDLE, "idle2_hold");

      // Held try counts once
      step(1'b1, 1'b0, 8'h00, 1'b0, O_IDLE, "held_enter");
      for (int i = 0; i < 5; i++)
         step(1'b1, 1'b0, 8'h5F, 1'b1, O_IDLE, $sformatf("held_try_%0d", i));
      step(1'b1, 1'b0, 8'h5F, 1'b0, O_IDLE, "held_rel");
      step(1'b1, 1'b0, 8'h5F, 1'b1, O_IDLE, "held_second_wrong");
      step(1'b1, 1'b0, 8'h5F, 1'b0, O_IDLE, "held_second_rel");
      step(1'b0, 1'b0, 8'h00, 1'b0, O_IDLE, "pin_s1_fall_idle");

      // Lockout; third wrong coincides with sensor_1 falling
      step(1'b1, 1'b0, 8'h00, 1'b0, O_IDLE, "lock_enter");
      step(1'b1, 1'b0, 8'h5F, 1'b1, O_IDLE, "lock_wrong_1");
      step(1'b1, 1'b0, 8'h5F, 1'b0, O_IDLE, "lock_rel_1");
      step(1'b1, 1'b0, 8'h5F, 1'b1, O_IDLE, "lock_wrong_2");
      step(1'b1, 1'b0, 8'h5F, 1'b0, O_IDLE, "lock_rel_2");
      step(1'b0, 1'b0, 8'h5F, 1'b1, O_LOCK, "lock_wrong_3");
      step(1'b1, 1'b1, 8'h57, 1'b0, O_LOCK, "lock_sensors");
      step(1'b1, 1'b0, 8'h57, 1'b1, O_LOCK, "lock_good_pin");
      step(1'b0, 1'b1, 8'h00, 1'b0, O_LOCK, "lock_s2");
      async_reset("lock_async_reset");
      step(1'b0, 1'b0, 8'h00, 1'b0, O_IDLE, "post_lock_idle");

      // Block from IDLE
      step(1'b1, 1'b1, 8'h00, 1'b0, O_BLOCK, "block_enter");
      step(1'b0, 1'b0, 8'h5F, 1'b1, O_BLOCK, "block_wrong");
      step(1'b0, 1'b0, 8'h5F, 1'b0, O_BLOCK, "block_rel");
      step(1'b1, 1'b1, 8'h57, 1'b1, O_IDLE,  "block_good_exit");
      step(1'b0, 1'b0, 8'h00, 1'b0, O_IDLE,  "block_after");

      // Tailgate, then async reset while open
      step(1'b1, 1'b0, 8'h00, 1'b0, O_IDLE,  "tg_pin");
      step(1'b1, 1'b0, 8'h57, 1'b1, O_AUTH,  "tg_auth");
      step(1'b1, 1'b1, 8'h00, 1'b0, O_BLOCK, "tg_block");
      step(1'b0, 1'b0, 8'h57, 1'b1, O_IDLE,  "tg_unblock");
      step(1'b1, 1'b0, 8'h00, 1'b0, O_IDLE,  "tg_pin2");
      step(1'b1, 1'b0, 8'h57, 1'b1, O_AUTH,  "tg_auth2");
      async_reset("auth_async_reset");

      // AUTH with no sensor_2
      step(1'b1, 1'b0, 8'h00, 1'b0, O_IDLE, "tmo_pin");
      step(1'b1, 1'b0, 8'h57, 1'b1, O_AUTH, "tmo_auth");
      for (int i = 1; i <= 200; i++) begin
`ifdef GATE_TIMEOUT_EN
         step(1'b0, 1'b0, 8'h00, 1'b0, (i >= 16) ? O_IDLE : O_AUTH, $sformatf("tmo_cycle_%0d", i));
`else
         step(1'b0, 1'b0, 8'h00, 1'b0, O_AUTH, $sformatf("auth_wait_%0d", i));
`endif
      end

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d responses still pending, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
